execute_stage_mdu: RTL and testbench
====================================

Name: execute_stage_mdu

Overview:
- Parametrised execute stage that generalises the current single-cycle EX stage to XLEN-bit data.
- Adds an iterative multiply/divide unit (RV M-extension) that stalls upstream while busy.
- Adds a flush input that squashes the EX instruction.
- Sits between the ID/EX register and the memory stage, and owns the EX/MEM pipeline register, operand forwarding and branch/jump resolution.

Parameters:
- XLEN, 32, datapath width; must be ≥8 and even.
- CNT_W, $clog2(XLEN)+1, MDU iteration-counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- InstrE  in  32  EX instruction; funct3=[14:12], bit30 = alt op
- RD1_E, RD2_E, PCE, ImmExtE, PCPlus4E  in  XLEN each  ID/EX operands
- RdE  in  5  destination register
- RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE, MulDivE  in  1 each  controls; MulDivE marks an M-ext instruction
- ALUControlE  in  3  ALU operation, existing encoding
- ResultSrcE  in  2  writeback select
- ForwardAE, ForwardBE  in  2 each  00=RD, 01=ResultW, 10=ALUResultM, 11=0
- ResultW  in  XLEN  writeback value
- FlushE  in  1  squash the EX instruction
- PCTargetE  out  XLEN  PCE+ImmExtE
- PCSrcE  out  1  redirect fetch
- MduBusyE  out  1  stall IF/ID/EX
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN each
- InstrM  out  32
- RdM  out  5
- RegWriteM, MemWriteM, JalrM  out  1 each
- ResultSrcM  out  2

Behaviour:

Combinational path
- SrcA = forward-mux A. SrcBfwd = forward-mux B. SrcB = ALUSrcE ? ImmExtE : SrcBfwd.
- The existing alu and branching_unit are reused at XLEN width. The branch decision uses the ALU result MSB, Zero and funct3.
- PCSrcE = ((take & BranchE) | JumpE) & ~MulDivE & ~FlushE.

MDU state machine: IDLE, BUSY, DONE
- IDLE → BUSY when MulDivE & ~FlushE.
  - Latch SrcA, SrcBfwd and funct3.
  - Set counter = XLEN-1.
- BUSY: one shift-add or restoring-subtract iteration per cycle. Decrement the counter. At 0 → DONE.
- DONE → IDLE unconditionally.
- FlushE in any state → IDLE next cycle. Partial results are discarded.
- MduBusyE = MulDivE & ~FlushE & (state != DONE). It is combinational and asserted in the start cycle.
- Latency: an M instruction occupies EX for exactly XLEN+2 cycles (start, XLEN iterations, DONE). For XLEN=32 that is 34 cycles.

MDU results (funct3)
- 0 MUL: low XLEN bits of the product.
- 1 MULH: high half, signed×signed.
- 2 MULHSU: high half, signed×unsigned.
- 3 MULHU: high half, unsigned×unsigned.
- 4 DIV / 5 DIVU: quotient, truncating toward zero.
- 6 REM / 7 REMU: remainder; sign follows the dividend.
- Divide by zero: quotient = all ones, remainder = dividend.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0.

EX/MEM register (async reset)
- Loads every cycle.
- Bubble (all controls 0, data 0) when FlushE, or when MulDivE and state != DONE.
- Otherwise loads RegWriteE, MemWriteE, ResultSrcE, JalrE, RdE, InstrE, PCPlus4E and WriteData = SrcBfwd.
- ALUResultM gets the MDU result in DONE, otherwise the ALU result.
- Forwarding into a stalled MDU start uses operands latched at start, so bubbles in M during BUSY cannot corrupt them.

Reset
- All M outputs = 0; state = IDLE; counter = 0; MduBusyE = 0; latched operands = 0.
- Reset mid-operation aborts the MDU immediately. After release no stale result is emitted.

Test Plan:
- Reset, then ADD with RD1=5, RD2=7, ForwardA=10, ALUResultM=100 → next cycle ALUResultM=107, RegWriteM=1.
- MUL 0xFFFFFFFF×0xFFFFFFFF (MulDivE=1, funct3=0), XLEN=32 → MduBusyE high 33 cycles, bubbles into M, then ALUResultM=0x00000001. MULHU on the same operands → 0xFFFFFFFE.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000. REM → 0. DIVU 7/0 → 0xFFFFFFFF. REMU 7/0 → 7.
- BEQ with equal operands, BranchE=1, PCE=0x100, Imm=0x20 → PCSrcE=1, PCTargetE=0x120. Same with FlushE=1 → PCSrcE=0 and a bubble in M.
- DIV start, then assert rst on busy cycle 10 → all outputs 0 and MduBusyE=0. After release, a fresh ADD completes in one cycle.
- FlushE on BUSY cycle 5 of MULH → next cycle state IDLE, MduBusyE=0, no write to M. Repeat the run with XLEN=16 and check the MDU latency is 18 cycles.

Source files
------------

// File: rtl/execute_stage_mdu_if.sv
// Signal bundle between the ID/EX register, the execute stage and the EX/MEM consumers.
// The slave modport is the execute stage's view; master is the surrounding pipeline.
interface execute_stage_mdu_if #(
    parameter int XLEN = 32
);
    logic [31:0]     InstrE;
    logic [XLEN-1:0] RD1_E;
    logic [XLEN-1:0] RD2_E;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] ImmExtE;
    logic [XLEN-1:0] PCPlus4E;
    logic [4:0]      RdE;
    logic            RegWriteE;
    logic            MemWriteE;
    logic            JumpE;
    logic            JalrE;
    logic            BranchE;
    logic            ALUSrcE;
    logic            MulDivE;
    logic [2:0]      ALUControlE;
    logic [1:0]      ResultSrcE;
    logic [1:0]      ForwardAE;
    logic [1:0]      ForwardBE;
    logic [XLEN-1:0] ResultW;
    logic            FlushE;

    logic [XLEN-1:0] PCTargetE;
    logic            PCSrcE;
    logic            MduBusyE;
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] PCPlus4M;
    logic [31:0]     InstrM;
    logic [4:0]      RdM;
    logic            RegWriteM;
    logic            MemWriteM;
    logic            JalrM;
    logic [1:0]      ResultSrcM;

    modport master (
        output InstrE, RD1_E, RD2_E, PCE, ImmExtE, PCPlus4E, RdE,
               RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE, MulDivE,
               ALUControlE, ResultSrcE, ForwardAE, ForwardBE, ResultW, FlushE,
        input  PCTargetE, PCSrcE, MduBusyE, ALUResultM, WriteDataM, PCPlus4M,
               InstrM, RdM, RegWriteM, MemWriteM, JalrM, ResultSrcM
    );

    modport slave (
        input  InstrE, RD1_E, RD2_E, PCE, ImmExtE, PCPlus4E, RdE,
               RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE, MulDivE,
               ALUControlE, ResultSrcE, ForwardAE, ForwardBE, ResultW, FlushE,
        output PCTargetE, PCSrcE, MduBusyE, ALUResultM, WriteDataM, PCPlus4M,
               InstrM, RdM, RegWriteM, MemWriteM, JalrM, ResultSrcM
    );
endinterface

// File: rtl/execute_stage_mdu.sv
// XLEN-wide execute stage: forwarding, ALU, branch resolution, EX/MEM register and an
// iterative M-extension unit (shift-add multiply, restoring divide) that stalls upstream.
module execute_stage_mdu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input logic                clk,
    input logic                rst,
    execute_stage_mdu_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? ({XLEN{1'b0}} - v) : v;
    endfunction

    // MULH, MULHSU, DIV and REM treat the first operand as signed.
    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
    endfunction

    logic [2:0]      funct3_s;
    logic [XLEN-1:0] src_a_s;
    logic [XLEN-1:0] src_b_fwd_s;
    logic [XLEN-1:0] src_b_s;
    logic [XLEN-1:0] alu_res_s;
    logic            alu_zero_s;
    logic            take_s;

    mdu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    logic            start_a_neg_s;
    logic [XLEN-1:0] start_mag_a_s;
    logic            a_neg_s;
    logic            b_neg_s;
    logic [XLEN-1:0] mag_b_s;
    logic            div_zero_s;
    logic [XLEN:0]   mul_sum_s;
    logic [XLEN:0]   div_shift_s;
    logic [XLEN:0]   div_diff_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0] quot_s;
    logic [XLEN-1:0] rem_s;
    logic [XLEN-1:0] mdu_res_s;

    logic [XLEN-1:0] alu_result_m_q, alu_result_m_d;
    logic [XLEN-1:0] write_data_m_q, write_data_m_d;
    logic [XLEN-1:0] pc_plus4_m_q, pc_plus4_m_d;
    logic [31:0]     instr_m_q, instr_m_d;
    logic [4:0]      rd_m_q, rd_m_d;
    logic            reg_write_m_q, reg_write_m_d;
    logic            mem_write_m_q, mem_write_m_d;
    logic            jalr_m_q, jalr_m_d;
    logic [1:0]      result_src_m_q, result_src_m_d;

    assign funct3_s = bus.InstrE[14:12];

    // Operand forwarding and immediate select.
    always_comb begin
        case (bus.ForwardAE)
            2'b00:   src_a_s = bus.RD1_E;
            2'b01:   src_a_s = bus.ResultW;
            2'b10:   src_a_s = alu_result_m_q;
            default: src_a_s = {XLEN{1'b0}};
        endcase
        case (bus.ForwardBE)
            2'b00:   src_b_fwd_s = bus.RD2_E;
            2'b01:   src_b_fwd_s = bus.ResultW;
            2'b10:   src_b_fwd_s = alu_result_m_q;
            default: src_b_fwd_s = {XLEN{1'b0}};
        endcase
        if (bus.ALUSrcE) begin
            src_b_s = bus.ImmExtE;
        end else begin
            src_b_s = src_b_fwd_s;
        end
    end

    // ALU.
    always_comb begin
        case (bus.ALUControlE)
            3'b000:  alu_res_s = src_a_s + src_b_s;
            3'b001:  alu_res_s = src_a_s - src_b_s;
            3'b010:  alu_res_s = src_a_s & src_b_s;
            3'b011:  alu_res_s = src_a_s | src_b_s;
            3'b100:  alu_res_s = src_a_s ^ src_b_s;
            3'b101:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(src_a_s) < $signed(src_b_s))};
            3'b110:  alu_res_s = src_a_s << src_b_s[SHW-1:0];
            3'b111:  alu_res_s = src_a_s >> src_b_s[SHW-1:0];
            default: alu_res_s = {XLEN{1'b0}};
        endcase
    end

    assign alu_zero_s = (alu_res_s == {XLEN{1'b0}});

    // Branch condition from the subtract result's sign and zero flags.
    always_comb begin
        case (funct3_s)
            3'b000:         take_s = alu_zero_s;
            3'b001:         take_s = ~alu_zero_s;
            3'b100, 3'b110: take_s = alu_res_s[XLEN-1];
            3'b101, 3'b111: take_s = ~alu_res_s[XLEN-1];
            default:        take_s = 1'b0;
        endcase
    end

    assign bus.PCTargetE = bus.PCE + bus.ImmExtE;
    assign bus.PCSrcE    = ((take_s & bus.BranchE) | bus.JumpE) & ~bus.MulDivE & ~bus.FlushE;
    assign bus.MduBusyE  = bus.MulDivE & ~bus.FlushE & (state_q != MDU_DONE) & ~rst;

    // Both iterations run on magnitudes; signs are reapplied when the result is read.
    assign start_a_neg_s = a_is_signed(funct3_s) & src_a_s[XLEN-1];
    assign start_mag_a_s = neg_if(src_a_s, start_a_neg_s);
    assign a_neg_s       = a_is_signed(f3_q) & op_a_q[XLEN-1];
    assign b_neg_s       = b_is_signed(f3_q) & op_b_q[XLEN-1];
    assign mag_b_s       = neg_if(op_b_q, b_neg_s);
    assign div_zero_s    = (op_b_q == {XLEN{1'b0}});
    assign mul_sum_s     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_b_s} : {(XLEN+1){1'b0}});
    assign div_shift_s   = {hi_q, lo_q[XLEN-1]};
    assign div_diff_s    = div_shift_s - {1'b0, mag_b_s};

    // Sign correction and result select; MIN/-1 falls out naturally as MIN rem 0.
    always_comb begin
        prod_s = {hi_q, lo_q};
        if (a_neg_s ^ b_neg_s) begin
            prod_s = {(2*XLEN){1'b0}} - {hi_q, lo_q};
        end else begin
            prod_s = {hi_q, lo_q};
        end
        quot_s = div_zero_s ? {XLEN{1'b1}} : neg_if(lo_q, a_neg_s ^ b_neg_s);
        rem_s  = div_zero_s ? op_a_q : neg_if(hi_q, a_neg_s);
        case (f3_q)
            3'd0:             mdu_res_s = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: mdu_res_s = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       mdu_res_s = quot_s;
            3'd6, 3'd7:       mdu_res_s = rem_s;
            default:          mdu_res_s = {XLEN{1'b0}};
        endcase
    end

    // MDU next state and one shift-add / restoring-subtract step per BUSY cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        f3_d    = f3_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MDU_IDLE: begin
                if (bus.MulDivE && !bus.FlushE) begin
                    state_d = MDU_BUSY;
                    cnt_d   = CNT_W'(XLEN - 1);
                    op_a_d  = src_a_s;
                    op_b_d  = src_b_fwd_s;
                    f3_d    = funct3_s;
                    hi_d    = {XLEN{1'b0}};
                    lo_d    = start_mag_a_s;
                end else begin
                    state_d = MDU_IDLE;
                end
            end
            MDU_BUSY: begin
                if (f3_q[2]) begin
                    if (!div_diff_s[XLEN]) begin
                        hi_d = div_diff_s[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = div_shift_s[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    hi_d = mul_sum_s[XLEN:1];
                    lo_d = {mul_sum_s[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = MDU_DONE;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            MDU_DONE: state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
        if (bus.FlushE) begin
            state_d = MDU_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // MDU state, counter and operand registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MDU_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            op_a_q  <= {XLEN{1'b0}};
            op_b_q  <= {XLEN{1'b0}};
            f3_q    <= 3'd0;
            hi_q    <= {XLEN{1'b0}};
            lo_q    <= {XLEN{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            f3_q    <= f3_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // EX/MEM contents: a bubble while squashed or while an M instruction is unfinished.
    always_comb begin
        if (bus.FlushE || (bus.MulDivE && (state_q != MDU_DONE))) begin
            alu_result_m_d = {XLEN{1'b0}};
            write_data_m_d = {XLEN{1'b0}};
            pc_plus4_m_d   = {XLEN{1'b0}};
            instr_m_d      = 32'd0;
            rd_m_d         = 5'd0;
            reg_write_m_d  = 1'b0;
            mem_write_m_d  = 1'b0;
            jalr_m_d       = 1'b0;
            result_src_m_d = 2'd0;
        end else begin
            alu_result_m_d = (state_q == MDU_DONE) ? mdu_res_s : alu_res_s;
            write_data_m_d = src_b_fwd_s;
            pc_plus4_m_d   = bus.PCPlus4E;
            instr_m_d      = bus.InstrE;
            rd_m_d         = bus.RdE;
            reg_write_m_d  = bus.RegWriteE;
            mem_write_m_d  = bus.MemWriteE;
            jalr_m_d       = bus.JalrE;
            result_src_m_d = bus.ResultSrcE;
        end
    end

    // EX/MEM pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_m_q <= {XLEN{1'b0}};
            write_data_m_q <= {XLEN{1'b0}};
            pc_plus4_m_q   <= {XLEN{1'b0}};
            instr_m_q      <= 32'd0;
            rd_m_q         <= 5'd0;
            reg_write_m_q  <= 1'b0;
            mem_write_m_q  <= 1'b0;
            jalr_m_q       <= 1'b0;
            result_src_m_q <= 2'd0;
        end else begin
            alu_result_m_q <= alu_result_m_d;
            write_data_m_q <= write_data_m_d;
            pc_plus4_m_q   <= pc_plus4_m_d;
            instr_m_q      <= instr_m_d;
            rd_m_q         <= rd_m_d;
            reg_write_m_q  <= reg_write_m_d;
            mem_write_m_q  <= mem_write_m_d;
            jalr_m_q       <= jalr_m_d;
            result_src_m_q <= result_src_m_d;
        end
    end

    assign bus.ALUResultM = alu_result_m_q;
    assign bus.WriteDataM = write_data_m_q;
    assign bus.PCPlus4M   = pc_plus4_m_q;
    assign bus.InstrM     = instr_m_q;
    assign bus.RdM        = rd_m_q;
    assign bus.RegWriteM  = reg_write_m_q;
    assign bus.MemWriteM  = mem_write_m_q;
    assign bus.JalrM      = jalr_m_q;
    assign bus.ResultSrcM = result_src_m_q;
endmodule

// File: tb/tb_execute_stage_mdu.sv
// Directed bench for execute_stage_mdu: ALU/forwarding, M-extension results and latency,
// branch resolution, flush and asynchronous reset, at XLEN=32 and XLEN=16.
module tb_execute_stage_mdu;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    execute_stage_mdu_if #(.XLEN(32)) b32 ();
    execute_stage_mdu_if #(.XLEN(16)) b16 ();

    execute_stage_mdu #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    execute_stage_mdu #(.XLEN(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear32();
        b32.InstrE = 32'd0;   b32.RD1_E = 32'd0;   b32.RD2_E = 32'd0;
        b32.PCE = 32'd0;      b32.ImmExtE = 32'd0; b32.PCPlus4E = 32'd0;
        b32.RdE = 5'd0;       b32.RegWriteE = 1'b0; b32.MemWriteE = 1'b0;
        b32.JumpE = 1'b0;     b32.JalrE = 1'b0;    b32.BranchE = 1'b0;
        b32.ALUSrcE = 1'b0;   b32.MulDivE = 1'b0;  b32.ALUControlE = 3'd0;
        b32.ResultSrcE = 2'd0; b32.ForwardAE = 2'd0; b32.ForwardBE = 2'd0;
        b32.ResultW = 32'd0;  b32.FlushE = 1'b0;
    endtask

    task automatic clear16();
        b16.InstrE = 32'd0;   b16.RD1_E = 16'd0;   b16.RD2_E = 16'd0;
        b16.PCE = 16'd0;      b16.ImmExtE = 16'd0; b16.PCPlus4E = 16'd0;
        b16.RdE = 5'd0;       b16.RegWriteE = 1'b0; b16.MemWriteE = 1'b0;
        b16.JumpE = 1'b0;     b16.JalrE = 1'b0;    b16.BranchE = 1'b0;
        b16.ALUSrcE = 1'b0;   b16.MulDivE = 1'b0;  b16.ALUControlE = 3'd0;
        b16.ResultSrcE = 2'd0; b16.ForwardAE = 2'd0; b16.ForwardBE = 2'd0;
        b16.ResultW = 16'd0;  b16.FlushE = 1'b0;
    endtask

    // Issue one M instruction on the 32-bit stage and follow it to the EX/MEM register.
    task automatic run_mdu32(input string tag, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int cyc;
        clear32();
        b32.InstrE = 32'h0200_0033;
        b32.InstrE[14:12] = f3;
        b32.MulDivE = 1'b1; b32.RegWriteE = 1'b1; b32.RdE = 5'd10;
        b32.RD1_E = a; b32.RD2_E = b;
        #1;
        cyc = 0;
        while (b32.MduBusyE && cyc < 100) begin
            cyc++;
            step();
            if (cyc == 1) check({tag, " bubble"}, {63'd0, b32.RegWriteM}, 64'd0);
        end
        check({tag, " busy"}, 64'(cyc), 64'd33);
        step();
        check({tag, " result"}, {32'd0, b32.ALUResultM}, {32'd0, exp});
        check({tag, " wr"}, {63'd0, b32.RegWriteM}, 64'd1);
        clear32();
    endtask

    task automatic run_mdu16(input string tag, input logic [2:0] f3,
                             input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
        int cyc;
        clear16();
        b16.InstrE = 32'h0200_0033;
        b16.InstrE[14:12] = f3;
        b16.MulDivE = 1'b1; b16.RegWriteE = 1'b1; b16.RdE = 5'd11;
        b16.RD1_E = a; b16.RD2_E = b;
        #1;
        cyc = 0;
        while (b16.MduBusyE && cyc < 100) begin
            cyc++;
            step();
        end
        step();
        check({tag, " latency"}, 64'(cyc + 1), 64'd18);
        check({tag, " result"}, {48'd0, b16.ALUResultM}, {48'd0, exp});
        clear16();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        clear32();
        clear16();
        repeat (2) @(posedge clk);
        #1;
        b32.MulDivE = 1'b1;
        #1;
        check("rst busy", {63'd0, b32.MduBusyE}, 64'd0);
        check("rst alures", {32'd0, b32.ALUResultM}, 64'd0);
        check("rst regwr", {63'd0, b32.RegWriteM}, 64'd0);
        check("rst instr", {32'd0, b32.InstrM}, 64'd0);
        clear32();
        rst = 1'b0;

        // ADD producing 100, then ADD forwarding it from M: 100 + 7.
        b32.RD1_E = 32'd100; b32.RegWriteE = 1'b1; b32.RdE = 5'd1;
        step();
        check("add1", {32'd0, b32.ALUResultM}, 64'd100);
        b32.RD1_E = 32'd5; b32.RD2_E = 32'd7; b32.ForwardAE = 2'b10; b32.RdE = 5'd2;
        step();
        check("add fwdM", {32'd0, b32.ALUResultM}, 64'd107);
        check("add regwr", {63'd0, b32.RegWriteM}, 64'd1);
        check("add rd", {59'd0, b32.RdM}, 64'd2);
        check("add wdata", {32'd0, b32.WriteDataM}, 64'd7);
        // SUB with B forwarded from writeback: 60 - 50.
        b32.ForwardAE = 2'b00; b32.ForwardBE = 2'b01; b32.ResultW = 32'd50;
        b32.RD1_E = 32'd60; b32.ALUControlE = 3'b001;
        step();
        check("sub fwdW", {32'd0, b32.ALUResultM}, 64'd10);
        check("sub wdata", {32'd0, b32.WriteDataM}, 64'd50);
        clear32();

        run_mdu32("mul", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_mdu32("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_mdu32("mulh", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
        run_mdu32("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_mdu32("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        run_mdu32("divu 0", 3'd5, 32'd7, 32'd0, 32'hFFFF_FFFF);
        run_mdu32("remu 0", 3'd7, 32'd7, 32'd0, 32'd7);
        run_mdu32("div neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_mdu32("rem neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);

        // Branches: SUB of the operands drives Zero / sign.
        b32.RD1_E = 32'd9; b32.RD2_E = 32'd9; b32.ALUControlE = 3'b001; b32.BranchE = 1'b1;
        b32.InstrE = 32'h0000_0063; b32.PCE = 32'h100; b32.ImmExtE = 32'h20;
        #1;
        check("beq taken", {63'd0, b32.PCSrcE}, 64'd1);
        check("pc target", {32'd0, b32.PCTargetE}, 64'h120);
        b32.RD2_E = 32'd8;
        #1;
        check("beq not", {63'd0, b32.PCSrcE}, 64'd0);
        b32.InstrE[14:12] = 3'd1;
        #1;
        check("bne taken", {63'd0, b32.PCSrcE}, 64'd1);
        b32.InstrE[14:12] = 3'd0; b32.RD2_E = 32'd9;
        b32.RegWriteE = 1'b1; b32.RdE = 5'd7; b32.FlushE = 1'b1;
        #1;
        check("beq flush", {63'd0, b32.PCSrcE}, 64'd0);
        step();
        check("flush regwr", {63'd0, b32.RegWriteM}, 64'd0);
        check("flush rd", {59'd0, b32.RdM}, 64'd0);
        clear32();

        // Asynchronous reset in the middle of a divide.
        b32.InstrE = 32'h0200_4033; b32.MulDivE = 1'b1; b32.RegWriteE = 1'b1; b32.RdE = 5'd9;
        b32.RD1_E = 32'd100; b32.RD2_E = 32'd3;
        #1;
        repeat (9) step();
        check("pre-rst busy", {63'd0, b32.MduBusyE}, 64'd1);
        rst = 1'b1;
        #1;
        check("midrst busy", {63'd0, b32.MduBusyE}, 64'd0);
        check("midrst alures", {32'd0, b32.ALUResultM}, 64'd0);
        check("midrst regwr", {63'd0, b32.RegWriteM}, 64'd0);
        step();
        clear32();
        rst = 1'b0;
        b32.RD1_E = 32'd2; b32.RD2_E = 32'd3; b32.RegWriteE = 1'b1; b32.RdE = 5'd4;
        step();
        check("post-rst add", {32'd0, b32.ALUResultM}, 64'd5);
        check("post-rst regwr", {63'd0, b32.RegWriteM}, 64'd1);
        clear32();
        repeat (2) step();
        check("no stale wr", {63'd0, b32.RegWriteM}, 64'd0);
        check("no stale res", {32'd0, b32.ALUResultM}, 64'd0);

        // Flush on the fifth busy cycle of MULH.
        b32.InstrE = 32'h0200_1033; b32.MulDivE = 1'b1; b32.RegWriteE = 1'b1; b32.RdE = 5'd12;
        b32.RD1_E = 32'hFFFF_FFFE; b32.RD2_E = 32'd3;
        #1;
        repeat (4) step();
        b32.FlushE = 1'b1;
        #1;
        check("flushmdu busy", {63'd0, b32.MduBusyE}, 64'd0);
        step();
        check("flushmdu regwr", {63'd0, b32.RegWriteM}, 64'd0);
        check("flushmdu res", {32'd0, b32.ALUResultM}, 64'd0);
        clear32();
        #1;
        check("flushmdu idle", {63'd0, b32.MduBusyE}, 64'd0);
        run_mdu32("mulh restart", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);

        run_mdu16("mul16", 3'd0, 16'hFFFF, 16'hFFFF, 16'h0001);
        run_mdu16("div16 ovf", 3'd4, 16'h8000, 16'hFFFF, 16'h8000);
        run_mdu16("mulhu16", 3'd3, 16'hFFFF, 16'hFFFF, 16'hFFFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
